pe_stim_driver: RTL and testbench
=================================

PE_STIM_DRIVER -- requirements
Module: pe_stim_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, PE operand width W; psum width is 2W.
REQ-002 SHALL have parameter KERNEL_SIZE, default 9, beats per window (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles waited for PE result.
REQ-004 SHALL have parameter SEED, default 32'hACE1_2024, LFSR reset value (nonzero).
REQ-005 SHALL have ports: clk in 1 clock; rstn in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: start in 1 run request; mode in 2 stimulus mode; num_windows in 16 windows per run.
REQ-007 SHALL have ports: ifmap_data_M2P out W; fltr_data_M2P out W; psum_data_M2P out 2W; kernel_size out 8 (= KERNEL_SIZE).
REQ-008 SHALL have ports: pe_en out 1 beat valid; pe_ready in 1 PE accepts beat; pe_valid in 1 result valid; psum_data_P2M in 2W PE result.
REQ-009 SHALL have ports: busy out 1; done out 1; err_cnt out 16 mismatches+timeouts; timeout_err out 1 sticky.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> WAIT_RES -> (LOAD | DONE); DONE -> LOAD on start, else hold.
REQ-011 IDLE/DONE: start=1 and num_windows>0 SHALL enter LOAD next cycle, clear err_cnt, timeout_err, window counter; num_windows=0 SHALL go directly to DONE.
REQ-012 start while busy (LOAD/WAIT_RES) SHALL be ignored.
REQ-013 Beat transfers at posedge where pe_en & pe_ready; pe_en=1 only in LOAD; data SHALL hold stable while pe_en & !pe_ready.
REQ-014 Beat counter SHALL advance per transfer; after beat KERNEL_SIZE-1 transfers, FSM SHALL enter WAIT_RES and deassert pe_en same edge.
REQ-015 psum_data_M2P SHALL be loaded at window start and held for all beats of that window.
REQ-016 Golden accumulator SHALL equal psum + sum(ifmap*fltr) over the window, each product 2W bits, all sums modulo 2^(2W).
REQ-017 mode 0 (and reserved 3): ifmap, fltr, psum from LFSR, new values per transfer (psum per window).
REQ-018 mode 1: ifmap = beat index+1, fltr = 1, psum = 0.
REQ-019 mode 2: ifmap = fltr = all-ones, psum = all-ones (overflow check).
REQ-020 mode SHALL be sampled at start; changes mid-run ignored.
REQ-021 WAIT_RES: pe_valid=1 SHALL compare psum_data_P2M to golden; mismatch increments err_cnt; then next window or DONE if last.
REQ-022 pe_valid in LOAD/IDLE/DONE SHALL be ignored.
REQ-023 WAIT_RES cycle counter reaching TIMEOUT without pe_valid SHALL set timeout_err, increment err_cnt, advance as in REQ-021.
REQ-024 err_cnt SHALL saturate at 16'hFFFF.
REQ-025 busy=1 in LOAD/WAIT_RES; done=1 in DONE only.
REQ-026 LFSR SHALL be 32-bit Galois, polynomial 32'h8020_0003, stepped once per operand draw; not reseeded by start.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE, all data outputs 0, pe_en 0, busy 0, done 0, err_cnt 0, timeout_err 0, counters 0, LFSR = SEED.
REQ-028 Reset mid-window SHALL abandon the window with no err_cnt update.

Structure
REQ-029 Package pe_drv_pkg SHALL hold state enum, mode enum, LFSR polynomial constant.
REQ-030 LFSR SHALL be sub-module pe_lfsr (enable, seed param, 32-bit state out).

Verification
REQ-031 mode 1, K=9, num_windows=1, ideal PE, pe_ready=1 -> 9 beats, ifmap 1..9, result 45, err_cnt 0, done.
REQ-032 mode 2, W=16, K=9 -> golden 32'hFFEE_0008; PE returns it -> err_cnt 0; returns 0 -> err_cnt 1.
REQ-033 pe_ready toggled 1/0 each cycle in mode 0 -> data stable while stalled, 9 transfers, results match, err_cnt 0.
REQ-034 num_windows=3, PE never asserts pe_valid -> each window waits 64 cycles, err_cnt 3, timeout_err 1, done.
REQ-035 rstn asserted at beat 4 of window 2 -> IDLE immediately, outputs 0; new start runs cleanly with err_cnt 0.
REQ-036 num_windows=0 start -> done next cycle, pe_en never asserted.

Source files
------------

// File: rtl/pe_drv_pkg.sv
// rtl/pe_drv_pkg.sv - shared types and LFSR step for the PE stimulus driver
package pe_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } drv_state_t;

    typedef enum logic [1:0] {
        MODE_LFSR = 2'd0,
        MODE_RAMP = 2'd1,
        MODE_ONES = 2'd2,
        MODE_RSVD = 2'd3
    } drv_mode_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/pe_lfsr.sv
// rtl/pe_lfsr.sv - 32-bit Galois LFSR that can advance up to three draws per cycle
module pe_lfsr
    import pe_drv_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [1:0]  draws,
    output logic [31:0] step1,
    output logic [31:0] step2,
    output logic [31:0] step3
);

    logic [31:0] state;

    // Each draw consumes the state reached after one more step.
    assign step1 = lfsr_next(state);
    assign step2 = lfsr_next(step1);
    assign step3 = lfsr_next(step2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SEED;
        end else if (en) begin
            case (draws)
                2'd1:    state <= step1;
                2'd2:    state <= step2;
                2'd3:    state <= step3;
                default: state <= state;
            endcase
        end
    end

endmodule

// File: rtl/pe_stim_driver.sv
// rtl/pe_stim_driver.sv - drives MAC windows into a PE and checks its psum against a golden sum
module pe_stim_driver
    import pe_drv_pkg::*;
#(
    parameter int          DATA_WIDTH  = 16,
    parameter int          KERNEL_SIZE = 9,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] SEED        = 32'hACE1_2024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [15:0]             num_windows,
    output logic [DATA_WIDTH-1:0]   ifmap_data_M2P,
    output logic [DATA_WIDTH-1:0]   fltr_data_M2P,
    output logic [2*DATA_WIDTH-1:0] psum_data_M2P,
    output logic [7:0]              kernel_size,
    output logic                    pe_en,
    input  logic                    pe_ready,
    input  logic                    pe_valid,
    input  logic [2*DATA_WIDTH-1:0] psum_data_P2M,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic                    timeout_err
);

    localparam int          PW     = 2 * DATA_WIDTH;
    localparam logic [7:0]  K_LAST = 8'(KERNEL_SIZE - 1);
    localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

    drv_state_t state, state_nxt;
    drv_mode_t  run_mode, win_mode;

    logic [15:0]           run_windows, win_cnt, wait_cnt;
    logic [7:0]            beat_cnt;
    logic [PW-1:0]         golden, prod, win_psum;
    logic [DATA_WIDTH-1:0] win_ifmap, win_fltr, nxt_ifmap, nxt_fltr;
    logic [31:0]           step1, step2, step3;
    logic                  run_go, xfer, last_beat, res_seen, res_timeout, win_close;
    logic                  last_win, win_start, beat_adv, err_hit, lfsr_en;
    logic [1:0]            lfsr_draws;

    assign kernel_size = 8'(KERNEL_SIZE);
    assign run_go      = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign xfer        = (state == ST_LOAD) && pe_ready;
    assign last_beat   = (beat_cnt == K_LAST);
    assign res_seen    = (state == ST_WAIT_RES) && pe_valid;
    assign res_timeout = (state == ST_WAIT_RES) && !pe_valid && (wait_cnt == T_LAST);
    assign win_close   = res_seen || res_timeout;
    assign last_win    = (win_cnt == run_windows - 16'd1);
    assign win_start   = (run_go && (num_windows != 16'd0)) || (win_close && !last_win);
    assign beat_adv    = xfer && !last_beat;
    assign err_hit     = (res_seen && (psum_data_P2M != golden)) || res_timeout;
    // The mode input only matters on the cycle a run is launched.
    assign win_mode    = run_go ? drv_mode_t'(mode) : run_mode;
    assign lfsr_en     = ((win_mode == MODE_LFSR) || (win_mode == MODE_RSVD)) && (win_start || beat_adv);
    assign lfsr_draws  = win_start ? 2'd3 : 2'd2;
    assign prod        = PW'(ifmap_data_M2P) * PW'(fltr_data_M2P);

    pe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .en    (lfsr_en),
        .draws (lfsr_draws),
        .step1 (step1),
        .step2 (step2),
        .step3 (step3)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = (num_windows != 16'd0) ? ST_LOAD : ST_DONE;
            ST_LOAD:          if (xfer && last_beat) state_nxt = ST_WAIT_RES;
            ST_WAIT_RES:      if (win_close) state_nxt = last_win ? ST_DONE : ST_LOAD;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pe_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            ST_LOAD:     begin pe_en = 1'b1; busy = 1'b1; end
            ST_WAIT_RES: busy = 1'b1;
            ST_DONE:     done = 1'b1;
            default:     ;
        endcase
    end

    always_comb begin
        case (win_mode)
            MODE_RAMP: begin
                win_psum  = '0;
                win_ifmap = DATA_WIDTH'(1);
                win_fltr  = DATA_WIDTH'(1);
                nxt_ifmap = DATA_WIDTH'(beat_cnt) + DATA_WIDTH'(2);
                nxt_fltr  = DATA_WIDTH'(1);
            end
            MODE_ONES: begin
                win_psum  = '1;
                win_ifmap = '1;
                win_fltr  = '1;
                nxt_ifmap = '1;
                nxt_fltr  = '1;
            end
            default: begin
                win_psum  = PW'(step1);
                win_ifmap = DATA_WIDTH'(step2);
                win_fltr  = DATA_WIDTH'(step3);
                nxt_ifmap = DATA_WIDTH'(step1);
                nxt_fltr  = DATA_WIDTH'(step2);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_mode    <= MODE_LFSR;
            run_windows <= '0;
            win_cnt     <= '0;
            beat_cnt    <= '0;
            wait_cnt    <= '0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (run_go) begin
                run_mode    <= drv_mode_t'(mode);
                run_windows <= num_windows;
                win_cnt     <= '0;
                err_cnt     <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (win_close && !last_win) win_cnt <= win_cnt + 16'd1;
                if (res_timeout) timeout_err <= 1'b1;
                if (err_hit && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
            end
            if (win_start)     beat_cnt <= '0;
            else if (beat_adv) beat_cnt <= beat_cnt + 8'd1;
            wait_cnt <= ((state == ST_WAIT_RES) && !win_close) ? wait_cnt + 16'd1 : 16'd0;
        end
    end

    // Operands stay registered so they hold while the PE stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ifmap_data_M2P <= '0;
            fltr_data_M2P  <= '0;
            psum_data_M2P  <= '0;
            golden         <= '0;
        end else if (win_start) begin
            psum_data_M2P  <= win_psum;
            ifmap_data_M2P <= win_ifmap;
            fltr_data_M2P  <= win_fltr;
            golden         <= win_psum;
        end else if (xfer) begin
            golden <= golden + prod;
            if (!last_beat) begin
                ifmap_data_M2P <= nxt_ifmap;
                fltr_data_M2P  <= nxt_fltr;
            end
        end
    end

endmodule

// File: tb/tb_pe_stim_driver.sv
// tb/tb_pe_stim_driver.sv - self-checking bench for pe_stim_driver
module tb_pe_stim_driver;

    localparam int          W    = 16;
    localparam int          K    = 9;
    localparam int          TO   = 64;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    logic           clk = 1'b0, rstn = 1'b0, start = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [15:0]    num_windows = 16'd0;
    logic [W-1:0]   ifmap_data_M2P, fltr_data_M2P;
    logic [2*W-1:0] psum_data_M2P, psum_data_P2M = '0;
    logic [7:0]     kernel_size;
    logic           pe_en, pe_ready = 1'b0, pe_valid = 1'b0, busy, done, timeout_err;
    logic [15:0]    err_cnt;

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    pe_stim_driver #(.DATA_WIDTH(W), .KERNEL_SIZE(K), .TIMEOUT(TO), .SEED(SEED)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .mode           (mode),
        .num_windows    (num_windows),
        .ifmap_data_M2P (ifmap_data_M2P),
        .fltr_data_M2P  (fltr_data_M2P),
        .psum_data_M2P  (psum_data_M2P),
        .kernel_size    (kernel_size),
        .pe_en          (pe_en),
        .pe_ready       (pe_ready),
        .pe_valid       (pe_valid),
        .psum_data_P2M  (psum_data_P2M),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .timeout_err    (timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] galois(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Run configuration: resp 0 = correct result, 1 = zero result, 2 = silent PE.
    int cfg_mode = 0, cfg_resp = 0, cfg_ready = 0, cfg_lat = 1;
    bit cfg_expect_to = 0;

    logic [31:0]    m_lfsr = SEED;
    logic [W-1:0]   e_ifm [K];
    logic [W-1:0]   e_flt [K];
    logic [2*W-1:0] e_psum, e_gold;
    int beat = 0, wins = 0, xfers = 0, wait_len = 0, resp_cnt = 0, en_seen = 0;
    bit win_open = 0;

    task automatic gen_window();
        if (cfg_mode == 1) begin
            e_psum = '0;
            for (int b = 0; b < K; b++) begin e_ifm[b] = W'(b + 1); e_flt[b] = W'(1); end
        end else if (cfg_mode == 2) begin
            e_psum = '1;
            for (int b = 0; b < K; b++) begin e_ifm[b] = '1; e_flt[b] = '1; end
        end else begin
            m_lfsr = galois(m_lfsr); e_psum = m_lfsr;
            for (int b = 0; b < K; b++) begin
                m_lfsr = galois(m_lfsr); e_ifm[b] = m_lfsr[W-1:0];
                m_lfsr = galois(m_lfsr); e_flt[b] = m_lfsr[W-1:0];
            end
        end
        e_gold = e_psum;
        for (int b = 0; b < K; b++) e_gold = e_gold + (2*W)'(e_ifm[b]) * (2*W)'(e_flt[b]);
    endtask

    // PE side and per-cycle compare, all at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_lfsr = SEED; beat = 0; win_open = 0; wait_len = 0; resp_cnt = 0;
                pe_valid = 1'b0; pe_ready = 1'b0;
                continue;
            end
            pe_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    pe_valid = 1'b1;
                    psum_data_P2M = (cfg_resp == 0) ? e_gold : '0;
                end
            end
            pe_ready = (cfg_ready == 0) ? 1'b1 : ~pe_ready;
            if (win_open && beat == K) begin
                if (pe_en || done) begin
                    check("wait_len_nonzero", wait_len != 0, 1);
                    if (cfg_expect_to) check("timeout_wait_cycles", wait_len, TO);
                    win_open = 0; wins++;
                end else if (busy) begin
                    wait_len++;
                end
            end
            if (pe_en) begin
                en_seen++;
                if (!win_open) begin gen_window(); win_open = 1; beat = 0; wait_len = 0; end
                check("ifmap", ifmap_data_M2P, e_ifm[beat]);
                check("fltr", fltr_data_M2P, e_flt[beat]);
                check("psum_m2p", psum_data_M2P, e_psum);
                check("busy_in_load", busy, 1);
                if (pe_ready) begin
                    xfers++; beat++;
                    if (beat == K && cfg_resp != 2) resp_cnt = cfg_lat;
                end
            end
        end
    end

    task automatic run(input int m, input int nw, input int resp, input int rdy, input int lat,
                       input int exp_err, input bit exp_to, input string tag);
        int cyc;
        cfg_mode = m; cfg_resp = resp; cfg_ready = rdy; cfg_lat = lat; cfg_expect_to = exp_to;
        @(negedge clk); #2;
        wins = 0; xfers = 0; start = 1'b1; mode = 2'(m); num_windows = 16'(nw);
        @(negedge clk); #2;
        start = 1'b0; mode = 2'(3 - m);
        repeat (4) @(negedge clk);
        #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin @(negedge clk); #2; cyc++; end
        check({tag, "_done"}, done, 1);
        check({tag, "_err_cnt"}, err_cnt, 64'(exp_err));
        check({tag, "_timeout_err"}, timeout_err, 64'(exp_to));
        check({tag, "_windows"}, wins, 64'(nw));
        check({tag, "_transfers"}, xfers, 64'(nw * K));
    endtask

    initial begin
        int cyc;
        check("lfsr_first_step", galois(SEED), 32'h5670_9012);
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pe_en", pe_en, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ifmap", ifmap_data_M2P, 0);
        check("rst_psum", psum_data_M2P, 0);
        check("kernel_size", kernel_size, 9);
        rstn = 1'b1;

        en_seen = 0;
        @(negedge clk); #2 start = 1'b1; num_windows = 16'd0; mode = 2'd1;
        @(negedge clk); #2 start = 1'b0;
        check("nw0_done", done, 1);
        check("nw0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("nw0_no_pe_en", en_seen, 0);

        run(1, 1, 0, 0, 1, 0, 0, "ramp");
        check("golden_ramp", e_gold, 45);
        run(2, 1, 0, 0, 2, 0, 0, "ones_ok");
        check("golden_ones", e_gold, 32'hFFEE_0008);
        run(2, 1, 1, 0, 1, 1, 0, "ones_bad");
        run(0, 2, 0, 1, 3, 0, 0, "toggle");
        run(3, 1, 0, 0, 1, 0, 0, "rsvd");
        run(0, 3, 2, 0, 1, 3, 1, "timeout");

        cfg_mode = 0; cfg_resp = 0; cfg_ready = 0; cfg_lat = 1; cfg_expect_to = 0;
        @(negedge clk); #2 wins = 0; start = 1'b1; mode = 2'd0; num_windows = 16'd3;
        @(negedge clk); #2 start = 1'b0;
        cyc = 0;
        while (!(wins == 1 && win_open && beat == 4) && cyc < 500) begin @(negedge clk); #2; cyc++; end
        check("reached_w2_beat4", cyc < 500, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_pe_en", pe_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        check("mid_rst_ifmap", ifmap_data_M2P, 0);
        check("mid_rst_fltr", fltr_data_M2P, 0);
        check("mid_rst_psum", psum_data_M2P, 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        run(0, 2, 0, 0, 2, 0, 0, "post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
